// File: rtl/reg_spill_fill.sv
// Spill/fill sequencer: walks register indices 0..NREGS-1, moving each register
// between the register bank and data memory with a req/ack memory handshake.
module reg_spill_fill #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    parameter int IDW   = 3,
    parameter int AW    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             dir,
    input  logic             abort,
    input  logic [AW-1:0]    base_addr,
    output logic             busy,
    output logic             done,
    output logic [IDW-1:0]   rId,
    input  logic [WIDTH-1:0] rOut,
    output logic [IDW-1:0]   wr_id,
    output logic [WIDTH-1:0] rIn,
    output logic             ldR,
    output logic             mem_req,
    output logic             mem_we,
    output logic [AW-1:0]    mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SP_RD,
        S_SP_WR,
        S_FL_RD,
        S_FL_LD,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [IDW-1:0]   r_idx;
    logic [AW-1:0]    r_base;
    logic             r_busy;
    logic             r_done;
    logic [IDW-1:0]   r_rid;
    logic [IDW-1:0]   r_wr_id;
    logic [WIDTH-1:0] r_rin;
    logic             r_ldr;
    logic             r_req;
    logic             r_we;
    logic [AW-1:0]    r_addr;
    logic [WIDTH-1:0] r_wdata;

    logic             w_last;
    logic [IDW-1:0]   w_idx_nxt;
    logic [AW-1:0]    w_addr_cur;
    logic [AW-1:0]    w_addr_nxt;

    assign w_last     = (r_idx == IDW'(NREGS - 1));
    assign w_idx_nxt  = r_idx + IDW'(1);
    // Address arithmetic deliberately wraps modulo 2^AW.
    assign w_addr_cur = r_base + AW'(r_idx);
    assign w_addr_nxt = r_base + AW'(w_idx_nxt);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_base  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_rid   <= '0;
            r_wr_id <= '0;
            r_rin   <= '0;
            r_ldr   <= 1'b0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_done <= 1'b0;
            r_ldr  <= 1'b0;
            // Abort wins over everything, including a same-cycle mem_ack.
            if (abort && r_state != S_IDLE) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_req   <= 1'b0;
                r_we    <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_base <= base_addr;
                            r_idx  <= '0;
                            r_busy <= 1'b1;
                            if (dir) begin
                                r_state <= S_FL_RD;
                                r_req   <= 1'b1;
                                r_we    <= 1'b0;
                                r_addr  <= base_addr;
                            end else begin
                                r_state <= S_SP_RD;
                                r_rid   <= '0;
                            end
                        end
                    end
                    S_SP_RD: begin
                        r_state <= S_SP_WR;
                        r_wdata <= rOut;
                        r_req   <= 1'b1;
                        r_we    <= 1'b1;
                        r_addr  <= w_addr_cur;
                    end
                    S_SP_WR: begin
                        if (mem_ack) begin
                            r_req <= 1'b0;
                            r_we  <= 1'b0;
                            if (w_last) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state <= S_SP_RD;
                                r_idx   <= w_idx_nxt;
                                r_rid   <= w_idx_nxt;
                            end
                        end
                    end
                    S_FL_RD: begin
                        if (mem_ack) begin
                            r_state <= S_FL_LD;
                            r_req   <= 1'b0;
                            r_ldr   <= 1'b1;
                            r_wr_id <= r_idx;
                            r_rin   <= mem_rdata;
                        end
                    end
                    S_FL_LD: begin
                        if (w_last) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= S_FL_RD;
                            r_idx   <= w_idx_nxt;
                            r_req   <= 1'b1;
                            r_we    <= 1'b0;
                            r_addr  <= w_addr_nxt;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_req   <= 1'b0;
                        r_we    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign rId       = r_rid;
    assign wr_id     = r_wr_id;
    assign rIn       = r_rin;
    // The strobe is already registered high for FL_LD; abort must still suppress it.
    assign ldR       = r_ldr & ~abort;
    assign mem_req   = r_req;
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

endmodule
